noc_msg_arbiter: RTL and testbench
==================================

Name: noc_msg_arbiter

Overview:
- Shares the inside port of the treeval AXI message FIFO (in/out P2P FIFOs, rdy/ack handshake) among N_REQ local requesters, e.g. tree-eval PEs.
- Outbound: round-robin arbitration of requester messages into the out FIFO.
- Inbound: routes each in-FIFO head message to the requester named in its ID field, then pops it.
- Sits between the PE array and the FIFO block. The two directions run as independent FSMs.

Parameters:
N_REQ, 4, number of requesters (2..8)
W_MSG, 64, message width; must match the FIFO
W_ID, 2, width of the requester-ID field at msg[W_MSG-1 -: W_ID]; requires 2**W_ID >= N_REQ

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_out_rdy  in  N_REQ  requester k holds a message for the out FIFO
req_out_msg  in  N_REQ*W_MSG  requester messages; slice k = bits [k*W_MSG +: W_MSG]
req_out_ack  out  N_REQ  one-cycle pulse: message k accepted
req_in_rdy  out  N_REQ  one-hot: inbound message valid for requester k
req_in_msg  out  W_MSG  inbound message, broadcast to all requesters
req_in_ack  in  N_REQ  requester k consumed the inbound message
fifo_out_rdy  out  1  drives FIFO i_out_msg_rdy
fifo_out_msg  out  W_MSG  drives FIFO i_out_msg
fifo_out_ack  in  1  from FIFO i_out_msg_ack
fifo_in_rdy  in  1  from FIFO i_in_msg_rdy
fifo_in_msg  in  W_MSG  from FIFO i_in_msg
fifo_in_ack  out  1  drives FIFO i_in_msg_ack
drop_cnt  out  8  count of inbound messages with invalid ID; saturates at 255
busy  out  1  either FSM is not idle

Behaviour:
- Reset (rst=1 at posedge): both FSMs return to IDLE. All outputs become 0, including drop_cnt. RR pointer = 0, grant cleared. Reset mid-transfer abandons the transfer with no ack to the requester.
- All outputs are registered.
- Requester contract:
  - hold req_out_rdy and req_out_msg stable until req_out_ack, then deassert before the next request.
  - Assert req_in_ack for exactly one cycle, and only while its own req_in_rdy is high.
- Outbound FSM, O_IDLE / O_SEND / O_DONE:
  - O_IDLE: if any req_out_rdy, pick the first set bit searching from ptr upward with wrap-around. Latch grant g and msg g, go to O_SEND.
  - O_SEND: fifo_out_rdy=1, fifo_out_msg = latched msg. Wait (unbounded) for fifo_out_ack=1, then go to O_DONE. fifo_out_rdy falls in the cycle after ack, so the FIFO never double-captures.
  - O_DONE: req_out_ack[g]=1 for exactly one cycle; ptr <= (g+1) mod N_REQ; go to O_IDLE.
  - Minimum latency: req_out_rdy at cycle t gives fifo_out_rdy at t+1. With a FIFO ack at t+2, req_out_ack pulses at t+3. Next grant no earlier than t+4.
  - A requester's rdy falling while in O_SEND is ignored; the latched message is still sent.
- Inbound FSM, I_IDLE / I_DELIVER / I_POP / I_GAP:
  - I_IDLE: if fifo_in_rdy, latch msg and id = msg[W_MSG-1 -: W_ID].
    - id < N_REQ: go to I_DELIVER.
    - else: drop_cnt += 1 (saturating), go to I_POP.
  - I_DELIVER: req_in_rdy[id]=1, req_in_msg = latched msg. Wait (unbounded) for req_in_ack[id]. req_in_ack on any other bit is ignored. Go to I_POP.
  - I_POP: fifo_in_ack=1 for exactly one cycle; go to I_GAP.
  - I_GAP: one idle cycle so the FIFO head advances before fifo_in_rdy is resampled; go to I_IDLE.
  - Latency: fifo_in_rdy at t gives req_in_rdy at t+1. req_in_ack at u gives fifo_in_ack at u+1.
- Simultaneous events: the outbound and inbound paths are fully concurrent. A requester may be granted outbound while receiving inbound. Multiple req_out_rdy bits in one cycle are resolved by the RR order only.
- busy = (outbound state != O_IDLE) || (inbound state != I_IDLE).

Optional Feature:
- Macro NOC_ARB_SRC_STAMP_EN.
- Defined: fifo_out_msg[W_MSG-1 -: W_ID] is replaced with the grant index g; the remaining bits pass through. A reply can then be routed back to the sender.
- Undefined: fifo_out_msg is the requester message unmodified.

Test Plan:
- Single outbound: req_out_rdy=4'b0100, msg2=64'hA5; FIFO acks 1 cycle after rdy -> fifo_out_msg=64'hA5 (stamped 64'h80..A5 if stamp enabled), req_out_ack=4'b0100 pulse at t+3, one FIFO capture only.
- Fairness: all four requesters hold rdy continuously, re-raising after each ack -> grant order 0,1,2,3,0,1 and no requester starves.
- Inbound routing: FIFO presents msg with top bits 2'b11 -> req_in_rdy=4'b1000. After req_in_ack[3]: fifo_in_ack pulses once; stray req_in_ack[1] earlier has no effect.
- Invalid ID with N_REQ=3: head msg ID=3 -> no req_in_rdy, fifo_in_ack pulses, drop_cnt 0->1. 300 such messages -> drop_cnt=255.
- Concurrency/backpressure: outbound held in O_SEND 10 cycles with no fifo_out_ack while two inbound messages deliver -> both delivered in order, and the outbound completes when ack arrives.
- Reset mid-op: rst in O_SEND and I_DELIVER -> next cycle all outputs 0, busy=0, ptr=0. The subsequent request from requester 1 is granted normally.

Source files
------------

// File: rtl/noc_msg_arbiter.sv
// Round-robin N_REQ:1 outbound mux and ID-routed inbound demux for a P2P message FIFO; req->fifo_out_rdy 1 cycle, fifo_in_rdy->req_in_rdy 1 cycle.
// Both sides wait indefinitely on the peer's ack; NOC_ARB_SRC_STAMP_EN overwrites the outbound ID field with the grant index.
module noc_msg_arbiter #(
    parameter int N_REQ = 4,
    parameter int W_MSG = 64,
    parameter int W_ID  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_out_rdy,
    input  logic [N_REQ*W_MSG-1:0] req_out_msg,
    output logic [N_REQ-1:0]       req_out_ack,
    output logic [N_REQ-1:0]       req_in_rdy,
    output logic [W_MSG-1:0]       req_in_msg,
    input  logic [N_REQ-1:0]       req_in_ack,
    output logic                   fifo_out_rdy,
    output logic [W_MSG-1:0]       fifo_out_msg,
    input  logic                   fifo_out_ack,
    input  logic                   fifo_in_rdy,
    input  logic [W_MSG-1:0]       fifo_in_msg,
    output logic                   fifo_in_ack,
    output logic [7:0]             drop_cnt,
    output logic                   busy
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IW-1:0] LAST = IW'(N_REQ - 1);

    typedef enum logic [1:0] {O_IDLE, O_SEND, O_DONE} o_state_t;
    typedef enum logic [1:0] {I_IDLE, I_DELIVER, I_POP, I_GAP} i_state_t;

    o_state_t          o_state_q, o_state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     grant_q, grant_d;
    logic [W_MSG-1:0]  out_msg_q, out_msg_d;
    logic              out_rdy_q, out_rdy_d;
    logic [N_REQ-1:0]  out_ack_q, out_ack_d;

    i_state_t          i_state_q, i_state_d;
    logic [W_MSG-1:0]  in_msg_q, in_msg_d;
    logic [N_REQ-1:0]  in_rdy_q, in_rdy_d;
    logic              in_ack_q, in_ack_d;
    logic [7:0]        drop_q, drop_d;
    logic              busy_q, busy_d;

    logic              pick_vld;
    logic [IW-1:0]     pick;
    logic [W_MSG-1:0]  pick_msg;
    logic [W_ID-1:0]   in_id;
    logic [N_REQ-1:0]  in_hit;
    logic              in_id_ok;

    // Round-robin search: lowest requester at or above ptr wins, else lowest below ptr.
    // Loops run high-to-low so the last assignment is the lowest match.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_out_rdy[k] && (IW'(k) < ptr_q)) begin
                pick_vld = 1'b1;
                pick     = IW'(k);
            end
        end
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_out_rdy[k] && (IW'(k) >= ptr_q)) begin
                pick_vld = 1'b1;
                pick     = IW'(k);
            end
        end
    end

    always_comb begin
        pick_msg = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (pick == IW'(k)) begin
                pick_msg = req_out_msg[k*W_MSG +: W_MSG];
            end
        end
`ifdef NOC_ARB_SRC_STAMP_EN
        pick_msg[W_MSG-1 -: W_ID] = W_ID'(pick);
`endif
    end

    // Outbound FSM
    always_comb begin
        o_state_d = o_state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        out_msg_d = out_msg_q;
        out_rdy_d = out_rdy_q;
        out_ack_d = '0;
        case (o_state_q)
            O_IDLE: begin
                if (pick_vld) begin
                    grant_d   = pick;
                    out_msg_d = pick_msg;
                    out_rdy_d = 1'b1;
                    o_state_d = O_SEND;
                end
            end
            O_SEND: begin
                if (fifo_out_ack) begin
                    out_rdy_d = 1'b0;
                    o_state_d = O_DONE;
                    for (int k = 0; k < N_REQ; k++) begin
                        out_ack_d[k] = (grant_q == IW'(k));
                    end
                end
            end
            O_DONE: begin
                ptr_d     = (grant_q == LAST) ? '0 : grant_q + 1'b1;
                o_state_d = O_IDLE;
            end
            default: o_state_d = O_IDLE;
        endcase
    end

    // ID decode doubles as the validity check: no hit means the ID names no requester.
    always_comb begin
        in_id    = fifo_in_msg[W_MSG-1 -: W_ID];
        in_hit   = '0;
        in_id_ok = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (in_id == W_ID'(k)) begin
                in_hit[k] = 1'b1;
                in_id_ok  = 1'b1;
            end
        end
    end

    // Inbound FSM
    always_comb begin
        i_state_d = i_state_q;
        in_msg_d  = in_msg_q;
        in_rdy_d  = in_rdy_q;
        in_ack_d  = 1'b0;
        drop_d    = drop_q;
        case (i_state_q)
            I_IDLE: begin
                if (fifo_in_rdy) begin
                    in_msg_d = fifo_in_msg;
                    if (in_id_ok) begin
                        in_rdy_d  = in_hit;
                        i_state_d = I_DELIVER;
                    end else begin
                        if (drop_q != 8'hFF) begin
                            drop_d = drop_q + 8'd1;
                        end
                        in_ack_d  = 1'b1;
                        i_state_d = I_POP;
                    end
                end
            end
            I_DELIVER: begin
                // Acks from requesters other than the addressed one are ignored.
                if (|(req_in_ack & in_rdy_q)) begin
                    in_rdy_d  = '0;
                    in_ack_d  = 1'b1;
                    i_state_d = I_POP;
                end
            end
            I_POP:   i_state_d = I_GAP;
            I_GAP:   i_state_d = I_IDLE;
            default: i_state_d = I_IDLE;
        endcase
    end

    always_comb begin
        busy_d = (o_state_d != O_IDLE) || (i_state_d != I_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_state_q <= O_IDLE;
            ptr_q     <= '0;
            grant_q   <= '0;
            out_msg_q <= '0;
            out_rdy_q <= 1'b0;
            out_ack_q <= '0;
            i_state_q <= I_IDLE;
            in_msg_q  <= '0;
            in_rdy_q  <= '0;
            in_ack_q  <= 1'b0;
            drop_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            o_state_q <= o_state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            out_msg_q <= out_msg_d;
            out_rdy_q <= out_rdy_d;
            out_ack_q <= out_ack_d;
            i_state_q <= i_state_d;
            in_msg_q  <= in_msg_d;
            in_rdy_q  <= in_rdy_d;
            in_ack_q  <= in_ack_d;
            drop_q    <= drop_d;
            busy_q    <= busy_d;
        end
    end

    assign fifo_out_rdy = out_rdy_q;
    assign fifo_out_msg = out_msg_q;
    assign req_out_ack  = out_ack_q;
    assign req_in_rdy   = in_rdy_q;
    assign req_in_msg   = in_msg_q;
    assign fifo_in_ack  = in_ack_q;
    assign drop_cnt     = drop_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_noc_msg_arbiter.sv
// Directed bench for noc_msg_arbiter: a 4-requester instance plus a 3-requester instance for invalid-ID drops.
module tb_noc_msg_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [3:0]   req_out_rdy;
    logic [255:0] req_out_msg;
    logic [3:0]   req_out_ack;
    logic [3:0]   req_in_rdy;
    logic [63:0]  req_in_msg;
    logic [3:0]   req_in_ack;
    logic         fifo_out_rdy;
    logic [63:0]  fifo_out_msg;
    logic         fifo_out_ack;
    logic         fifo_in_rdy;
    logic [63:0]  fifo_in_msg;
    logic         fifo_in_ack;
    logic [7:0]   drop_cnt;
    logic         busy;

    logic [2:0]   r3_req_out_ack;
    logic [2:0]   r3_req_in_rdy;
    logic [63:0]  r3_req_in_msg;
    logic         r3_fifo_out_rdy;
    logic [63:0]  r3_fifo_out_msg;
    logic         r3_fifo_in_rdy;
    logic [63:0]  r3_fifo_in_msg;
    logic         r3_fifo_in_ack;
    logic [7:0]   r3_drop_cnt;
    logic         r3_busy;
    logic [2:0]   r3_zero3;
    logic [191:0] r3_zero_msg;

    noc_msg_arbiter #(.N_REQ(4), .W_MSG(64), .W_ID(2)) u_dut (
        .clk(clk), .rst(rst),
        .req_out_rdy(req_out_rdy), .req_out_msg(req_out_msg), .req_out_ack(req_out_ack),
        .req_in_rdy(req_in_rdy), .req_in_msg(req_in_msg), .req_in_ack(req_in_ack),
        .fifo_out_rdy(fifo_out_rdy), .fifo_out_msg(fifo_out_msg), .fifo_out_ack(fifo_out_ack),
        .fifo_in_rdy(fifo_in_rdy), .fifo_in_msg(fifo_in_msg), .fifo_in_ack(fifo_in_ack),
        .drop_cnt(drop_cnt), .busy(busy)
    );

    noc_msg_arbiter #(.N_REQ(3), .W_MSG(64), .W_ID(2)) u_dut3 (
        .clk(clk), .rst(rst),
        .req_out_rdy(r3_zero3), .req_out_msg(r3_zero_msg), .req_out_ack(r3_req_out_ack),
        .req_in_rdy(r3_req_in_rdy), .req_in_msg(r3_req_in_msg), .req_in_ack(r3_zero3),
        .fifo_out_rdy(r3_fifo_out_rdy), .fifo_out_msg(r3_fifo_out_msg), .fifo_out_ack(1'b0),
        .fifo_in_rdy(r3_fifo_in_rdy), .fifo_in_msg(r3_fifo_in_msg), .fifo_in_ack(r3_fifo_in_ack),
        .drop_cnt(r3_drop_cnt), .busy(r3_busy)
    );

    int checks = 0;
    int errors = 0;
    int cap_cnt = 0;
    int pop_cnt = 0;

    // FIFO-side event counters: out captures and in pops.
    always @(posedge clk) begin
        if (fifo_out_rdy && fifo_out_ack) cap_cnt++;
        if (fifo_in_ack) pop_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [63:0] stamp(input logic [63:0] m, input logic [1:0] g);
        logic [63:0] r;
        r = m;
`ifdef NOC_ARB_SRC_STAMP_EN
        r[63:62] = g;
`endif
        return r;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int cap0, pop0, eg, w;
        logic [63:0] m;
        rst = 1'b1;
        req_out_rdy = '0; req_out_msg = '0; req_in_ack = '0;
        fifo_out_ack = 1'b0; fifo_in_rdy = 1'b0; fifo_in_msg = '0;
        r3_fifo_in_rdy = 1'b0; r3_fifo_in_msg = '0;
        r3_zero3 = '0; r3_zero_msg = '0;
        tick(); tick();

        // Reset state
        chk("rst_fifo_out_rdy", fifo_out_rdy, 0);
        chk("rst_fifo_out_msg", fifo_out_msg, 0);
        chk("rst_req_out_ack", req_out_ack, 0);
        chk("rst_req_in_rdy", req_in_rdy, 0);
        chk("rst_req_in_msg", req_in_msg, 0);
        chk("rst_fifo_in_ack", fifo_in_ack, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_r3_drop_cnt", r3_drop_cnt, 0);
        rst = 1'b0;

        // Single outbound from requester 2, FIFO acks one cycle after rdy
        req_out_msg[2*64 +: 64] = 64'hA5;
        req_out_rdy = 4'b0100;
        cap0 = cap_cnt;
        tick();
        chk("t1_fifo_rdy", fifo_out_rdy, 1);
        chk("t1_fifo_msg", fifo_out_msg, stamp(64'hA5, 2'd2));
        chk("t1_busy", busy, 1);
        tick();
        chk("t1_no_early_ack", req_out_ack, 0);
        fifo_out_ack = 1'b1;
        tick();
        fifo_out_ack = 1'b0;
        chk("t1_req_ack", req_out_ack, 4'b0100);
        chk("t1_rdy_fall", fifo_out_rdy, 0);
        req_out_rdy = 4'b0000;
        tick();
        chk("t1_ack_pulse", req_out_ack, 0);
        chk("t1_one_capture", cap_cnt - cap0, 1);
        chk("t1_idle", busy, 0);

        // Fairness: all four requesting, each re-raises right after its ack
        do_reset();
        for (int k = 0; k < 4; k++) req_out_msg[k*64 +: 64] = 64'h100 + k;
        req_out_rdy = 4'hF;
        for (int n = 0; n < 6; n++) begin
            eg = n % 4;
            w = 0;
            while (!fifo_out_rdy && w < 20) begin tick(); w++; end
            chk("rr_send", fifo_out_rdy, 1);
            chk("rr_msg", fifo_out_msg, stamp(64'h100 + eg, eg[1:0]));
            fifo_out_ack = 1'b1;
            tick();
            fifo_out_ack = 1'b0;
            chk("rr_ack", req_out_ack, 64'd1 << eg);
            req_out_rdy[eg] = 1'b0;
            tick();
            if (n < 5) req_out_rdy[eg] = 1'b1;
            else req_out_rdy = 4'b0000;
        end
        tick();
        chk("rr_idle", busy, 0);

        // Inbound routing to requester 3, stray ack from requester 1 ignored
        do_reset();
        m = {2'b11, 62'h123};
        fifo_in_msg = m;
        fifo_in_rdy = 1'b1;
        pop0 = pop_cnt;
        tick();
        chk("in_rdy", req_in_rdy, 4'b1000);
        chk("in_msg", req_in_msg, m);
        req_in_ack = 4'b0010;
        tick();
        req_in_ack = 4'b0000;
        chk("in_stray_rdy", req_in_rdy, 4'b1000);
        chk("in_stray_pop", fifo_in_ack, 0);
        req_in_ack = 4'b1000;
        tick();
        req_in_ack = 4'b0000;
        chk("in_pop", fifo_in_ack, 1);
        chk("in_rdy_clr", req_in_rdy, 0);
        fifo_in_rdy = 1'b0;
        tick();
        chk("in_pop_pulse", fifo_in_ack, 0);
        tick(); tick();
        chk("in_pop_once", pop_cnt - pop0, 1);
        chk("in_idle", busy, 0);

        // Invalid ID on the 3-requester instance; then saturate the drop counter
        r3_fifo_in_msg = {2'b11, 62'h7};
        r3_fifo_in_rdy = 1'b1;
        tick();
        chk("drop_no_rdy", r3_req_in_rdy, 0);
        chk("drop_pop", r3_fifo_in_ack, 1);
        chk("drop_cnt1", r3_drop_cnt, 1);
        repeat (900) tick();
        r3_fifo_in_rdy = 1'b0;
        tick(); tick(); tick();
        chk("drop_sat", r3_drop_cnt, 255);
        chk("drop_dut4_zero", drop_cnt, 0);

        // Outbound stalled in send while two inbound messages deliver in order
        do_reset();
        req_out_msg[2*64 +: 64] = 64'h55;
        req_out_rdy = 4'b0100;
        fifo_in_msg = {2'b01, 62'hA};
        fifo_in_rdy = 1'b1;
        cap0 = cap_cnt;
        tick();
        chk("cc_send", fifo_out_rdy, 1);
        chk("cc_a_rdy", req_in_rdy, 4'b0010);
        chk("cc_a_msg", req_in_msg, {2'b01, 62'hA});
        req_in_ack = 4'b0010;
        tick();
        req_in_ack = 4'b0000;
        chk("cc_a_pop", fifo_in_ack, 1);
        fifo_in_msg = {2'b10, 62'hB};
        tick(); tick(); tick();
        chk("cc_b_rdy", req_in_rdy, 4'b0100);
        chk("cc_b_msg", req_in_msg, {2'b10, 62'hB});
        req_in_ack = 4'b0100;
        tick();
        req_in_ack = 4'b0000;
        chk("cc_b_pop", fifo_in_ack, 1);
        fifo_in_rdy = 1'b0;
        repeat (4) tick();
        chk("cc_hold_rdy", fifo_out_rdy, 1);
        chk("cc_hold_msg", fifo_out_msg, stamp(64'h55, 2'd2));
        chk("cc_hold_no_ack", req_out_ack, 0);
        chk("cc_no_capture", cap_cnt - cap0, 0);
        fifo_out_ack = 1'b1;
        tick();
        fifo_out_ack = 1'b0;
        chk("cc_out_ack", req_out_ack, 4'b0100);
        req_out_rdy = 4'b0000;
        tick();
        chk("cc_idle", busy, 0);

        // Reset while in send (grant 3, ptr 3) and deliver; ptr must return to 0
        req_out_msg[1*64 +: 64] = 64'h11;
        req_out_msg[3*64 +: 64] = 64'h33;
        req_out_rdy = 4'b1000;
        fifo_in_msg = {2'b00, 62'hC};
        fifo_in_rdy = 1'b1;
        tick();
        chk("mr_send", fifo_out_rdy, 1);
        chk("mr_send_msg", fifo_out_msg, stamp(64'h33, 2'd3));
        chk("mr_deliver", req_in_rdy, 4'b0001);
        rst = 1'b1;
        req_out_rdy = 4'b1010;
        fifo_in_rdy = 1'b0;
        tick();
        rst = 1'b0;
        chk("mr_fifo_out_rdy", fifo_out_rdy, 0);
        chk("mr_fifo_out_msg", fifo_out_msg, 0);
        chk("mr_req_out_ack", req_out_ack, 0);
        chk("mr_req_in_rdy", req_in_rdy, 0);
        chk("mr_req_in_msg", req_in_msg, 0);
        chk("mr_fifo_in_ack", fifo_in_ack, 0);
        chk("mr_busy", busy, 0);
        tick();
        chk("mr_regrant_rdy", fifo_out_rdy, 1);
        chk("mr_regrant_msg", fifo_out_msg, stamp(64'h11, 2'd1));
        chk("mr_no_stale_ack", req_out_ack, 0);
        fifo_out_ack = 1'b1;
        tick();
        fifo_out_ack = 1'b0;
        chk("mr_ack1", req_out_ack, 4'b0010);
        req_out_rdy = 4'b0000;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
